// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, line levels, frame constants and parity helper.
// The PARITY state is only reached in builds with UART_TX_PARITY_EN defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } uart_state_e;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned UART_CLKS_PER_BIT_DEF = 434;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Shared between the TX serializer and the RX block.
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned CNT_W        = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_tick
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_r;

  assign bit_tick = (count_r == LAST_CNT);

  // Counter wraps on the last cycle of each bit so every bit starts at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clear || bit_tick) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: 8N1 framing, LSB first, with registered line/done/active outputs.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_data_valid,
  input  logic [7:0] tx_byte,
  output logic       o_tx_serial,
  output logic       o_tx_done,
  output logic       o_tx_active
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_e state_r, state_nxt;
  logic [2:0]  bit_idx_r, bit_idx_nxt;
  logic [7:0]  shift_r, shift_nxt;
  logic        serial_nxt, done_nxt, active_nxt;
  logic        bit_tick_s;
  logic        cnt_clear_s;

  // Counter is held at zero while idle so the start bit gets a full period
  assign cnt_clear_s = (state_r == IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cnt_clear_s),
    .bit_tick(bit_tick_s)
  );

  // State, data and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'd0;
      o_tx_serial <= UART_IDLE_LVL;
      o_tx_done   <= 1'b1;
      o_tx_active <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      bit_idx_r   <= bit_idx_nxt;
      shift_r     <= shift_nxt;
      o_tx_serial <= serial_nxt;
      o_tx_done   <= done_nxt;
      o_tx_active <= active_nxt;
    end
  end

  // Next-state and next-output logic; outputs change on the edge that changes state
  always_comb begin
    state_nxt   = state_r;
    bit_idx_nxt = bit_idx_r;
    shift_nxt   = shift_r;
    serial_nxt  = o_tx_serial;
    done_nxt    = o_tx_done;
    active_nxt  = o_tx_active;
    case (state_r)
      IDLE: begin
        if (tx_data_valid) begin
          state_nxt   = START;
          shift_nxt   = tx_byte;
          bit_idx_nxt = 3'd0;
          serial_nxt  = UART_START_LVL;
          done_nxt    = 1'b0;
          active_nxt  = 1'b1;
        end else begin
          serial_nxt  = UART_IDLE_LVL;
          done_nxt    = 1'b1;
          active_nxt  = 1'b0;
        end
      end
      START: begin
        if (bit_tick_s) begin
          state_nxt   = DATA;
          bit_idx_nxt = 3'd0;
          serial_nxt  = shift_r[0];
        end else begin
          serial_nxt  = UART_START_LVL;
        end
      end
      DATA: begin
        if (bit_tick_s) begin
          if (bit_idx_r == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_nxt  = PARITY;
            serial_nxt = even_parity(shift_r);
`else
            state_nxt  = STOP;
            serial_nxt = UART_STOP_LVL;
`endif
          end else begin
            bit_idx_nxt = bit_idx_r + 3'd1;
            serial_nxt  = shift_r[bit_idx_r + 3'd1];
          end
        end else begin
          serial_nxt = shift_r[bit_idx_r];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick_s) begin
          state_nxt  = STOP;
          serial_nxt = UART_STOP_LVL;
        end else begin
          serial_nxt = even_parity(shift_r);
        end
      end
`endif
      STOP: begin
        if (bit_tick_s) begin
          state_nxt  = IDLE;
          serial_nxt = UART_IDLE_LVL;
          done_nxt   = 1'b1;
          active_nxt = 1'b0;
        end else begin
          serial_nxt = UART_STOP_LVL;
        end
      end
      default: begin
        state_nxt   = IDLE;
        bit_idx_nxt = 3'd0;
        serial_nxt  = UART_IDLE_LVL;
        done_nxt    = 1'b1;
        active_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer (CLKS_PER_BIT=4): vector table, random frames,
// controller-style handshake with a line decoder, back-to-back and mid-frame reset sequences.
module tb_uart_tx_serializer;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_data_valid = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       o_tx_serial, o_tx_done, o_tx_active;

  int         tests = 0;
  int         fails = 0;
  logic       mon_en = 1'b0;
  logic [7:0] mon_q[$];

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_data_valid(tx_data_valid),
    .tx_byte      (tx_byte),
    .o_tx_serial  (o_tx_serial),
    .o_tx_done    (o_tx_done),
    .o_tx_active  (o_tx_active)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference line level t cycles after acceptance: frame bit list indexed by bit period
  function automatic logic exp_line(input logic [7:0] b, input int t);
    logic bits[NB];
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
    bits[9] = ^b;
    bits[NB-1] = 1'b1;
    return bits[t / CPB];
  endfunction

  task automatic send_accept(input logic [7:0] b);
    tx_byte = b;
    tx_data_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input int n, input string tag);
    int errs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (o_tx_serial !== 1'b1 || o_tx_done !== 1'b1 || o_tx_active !== 1'b0) errs++;
    end
    check(tag, errs, 0);
  endtask

  // Called at the negedge right after the accepting edge (t=0); ends at t=FRAME
  task automatic run_frame(input logic [7:0] b, input logic [7:0] exp_byte, input int g_t,
                           input logic [7:0] g_d, input bit hold, input string tag,
                           output logic par_seen);
    int errs = 0;
    int done_t = -1;
    logic [7:0] dec = 8'h00;
    par_seen = 1'bx;
    for (int t = 0; t <= FRAME; t++) begin
      if (t > 0) @(negedge clk);
      if (t < FRAME) begin
        if (o_tx_serial !== exp_line(b, t) || o_tx_done !== 1'b0 || o_tx_active !== 1'b1) errs++;
      end else begin
        if (o_tx_serial !== 1'b1 || o_tx_active !== 1'b0) errs++;
      end
      if (o_tx_done === 1'b1 && done_t < 0) done_t = t;
      if ((t % CPB) == CPB / 2 && t / CPB >= 1 && t / CPB <= 8) dec[t / CPB - 1] = o_tx_serial;
      if (t == 9 * CPB + CPB / 2) par_seen = o_tx_serial;
      if (!hold && t == 0) tx_data_valid = 1'b0;
      if (t == g_t) begin
        tx_byte = g_d;
        if (!hold) tx_data_valid = 1'b1;
      end else if (t == g_t + 1 && !hold) begin
        tx_data_valid = 1'b0;
      end
    end
    check({tag, "_wave"}, errs, 0);
    check({tag, "_byte"}, dec, exp_byte);
    check({tag, "_done_t"}, done_t, FRAME);
  endtask

  // Line decoder used during the handshake test: mid-bit sampling after a start bit
  initial begin
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n === 1'b1 && o_tx_serial === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          d[i] = o_tx_serial;
        end
        repeat (NB - 9) @(negedge clk) begin end
        repeat ((NB - 9) * CPB - (NB - 9)) @(negedge clk);
        check("mon_stop", o_tx_serial, 1'b1);
        mon_q.push_back(d);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    int         g_t;
    logic [7:0] g_d;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t       vecs[5];
  logic [7:0] msg[12];
  logic       par;
  int         n;

  initial begin
    vecs[0] = '{8'h53, -5, 8'h00, 8'h53};
    vecs[1] = '{8'hA5, 10, 8'hFF, 8'hA5};
    vecs[2] = '{8'h00, 0, 8'hFF, 8'h00};
    vecs[3] = '{8'hFF, FRAME - 1, 8'h00, 8'hFF};
    vecs[4] = '{8'h80, FRAME / 2, 8'h55, 8'h80};
    msg = '{8'h53, 8'h49, 8'h2D, 8'h53, 8'h49, 8'h4D, 8'h31, 8'h2D, 8'h50, 8'h2D, 8'h23, 8'h0D};

    // Reset state, then released idle
    repeat (3) @(negedge clk);
    check("rst_serial", o_tx_serial, 1'b1);
    check("rst_done", o_tx_done, 1'b1);
    check("rst_active", o_tx_active, 1'b0);
    rst_n = 1'b1;
    check_idle(20, "post_rst_idle");

    // Vector table: frame shape plus busy-valid pulses that must be ignored
    for (int i = 0; i < 5; i++) begin
      send_accept(vecs[i].data);
      run_frame(vecs[i].data, vecs[i].exp_byte, vecs[i].g_t, vecs[i].g_d, 1'b0, $sformatf("vec%0d", i), par);
      check_idle(2 * FRAME, $sformatf("vec%0d_no_extra", i));
    end

    // Random frames with random busy pulses and idle gaps
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      int gt;
      b  = 8'($urandom_range(0, 255));
      gt = ($urandom_range(0, 3) == 0) ? -5 : int'($urandom_range(0, FRAME - 1));
      send_accept(b);
      run_frame(b, b, gt, 8'($urandom_range(0, 255)), 1'b0, $sformatf("rnd%0d", i), par);
      check_idle(int'($urandom_range(2, 8)), $sformatf("rnd%0d_idle", i));
    end

    // Back-to-back: valid held high, byte changed mid-frame, next frame after 1 idle clk
    send_accept(8'h3C);
    run_frame(8'h3C, 8'h3C, 3, 8'hC5, 1'b1, "b2b_a", par);
    @(negedge clk);
    tx_data_valid = 1'b0;
    run_frame(8'hC5, 8'hC5, -5, 8'h00, 1'b0, "b2b_b", par);
    check_idle(10, "b2b_idle");

    // Controller-style SEND/WAIT handshake for a 12-byte message
    mon_q.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tx_byte = msg[i];
      tx_data_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (o_tx_done !== 1'b0 && n < 10) begin
        @(negedge clk);
        n++;
      end
      tx_data_valid = 1'b0;
      check($sformatf("hs%0d_accept", i), n, 0);
      n = 0;
      while (o_tx_done !== 1'b1 && n < FRAME + 10) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("hs%0d_len", i), n, FRAME);
    end
    mon_en = 1'b0;
    repeat (4) @(negedge clk);
    check("hs_frames", mon_q.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < mon_q.size()) check($sformatf("hs_byte%0d", i), mon_q[i], msg[i]);
    end

    // Reset during data bit 3, then a clean 0x0D frame
    send_accept(8'h5A);
    tx_data_valid = 1'b0;
    repeat (17) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_serial", o_tx_serial, 1'b1);
    check("midrst_done", o_tx_done, 1'b1);
    check("midrst_active", o_tx_active, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    check_idle(5, "midrst_idle");
    send_accept(8'h0D);
    run_frame(8'h0D, 8'h0D, -5, 8'h00, 1'b0, "after_rst", par);

`ifdef UART_TX_PARITY_EN
    send_accept(8'h07);
    run_frame(8'h07, 8'h07, -5, 8'h00, 1'b0, "par07", par);
    check("par07_bit", par, 1'b1);
    check_idle(3, "par07_idle");
    send_accept(8'h03);
    run_frame(8'h03, 8'h03, -5, 8'h00, 1'b0, "par03", par);
    check("par03_bit", par, 1'b0);
`endif

    check_idle(5, "final_idle");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Byte-to-serial UART transmitter that sits directly downstream of the message controller. It consumes tx_byte/tx_data_valid and drives the board TX pin with 8N1 framing, LSB first. It returns o_tx_done, which the controller uses for its SEND/WAIT handshake: high when idle, low while a frame is in flight. One instance per UART link; the TX pin goes straight to the pad.

Parameters:
CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200); legal range 2..65535
CNT_W, 16, width of the baud counter; must hold CLKS_PER_BIT-1

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
tx_data_valid  in  1  request to send tx_byte; level-sampled only in IDLE
tx_byte  in  8  byte to transmit; captured on acceptance
o_tx_serial  out  1  UART TX line, idles high
o_tx_done  out  1  high = idle/ready; low = frame in progress
o_tx_active  out  1  high from acceptance through end of stop bit

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, o_tx_serial=1, o_tx_done=1, o_tx_active=0, baud count=0, bit index=0, shift register=0.
- All outputs are registered; no combinational path from input to output.
- FSM states: IDLE, START, DATA, STOP (PARITY is added only with the optional feature).
- IDLE: if tx_data_valid=1 at edge k, capture tx_byte into the shift register and go to START. At edge k, o_tx_serial<=0, o_tx_done<=0, o_tx_active<=1. Otherwise hold outputs.
- START: hold line low for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: drive shift_reg[bit_index] for CLKS_PER_BIT cycles each, LSB first. After bit 7 completes, go to STOP.
- STOP: drive line high for CLKS_PER_BIT cycles. On the final cycle, go to IDLE with o_tx_done<=1 and o_tx_active<=0.
- Frame timing: o_tx_done returns high at edge k+10*CLKS_PER_BIT. Each bit lasts exactly CLKS_PER_BIT cycles.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets to 0 on every state or bit change; no free-running drift.
- tx_data_valid while busy: ignored; tx_byte changes mid-frame do not affect the frame.
- Back-to-back: if valid is still high in the IDLE cycle after STOP, the next frame is accepted there. Minimum inter-frame gap is 1 clk of idle-high line beyond the stop bit.
- Controller handshake: the controller holds valid until it sees done=0 (one cycle after acceptance), then waits for done=1. A 12-byte message must produce exactly 12 frames with no duplicates. Guarantee: valid is never re-sampled while done=0.
- Reset mid-frame: the line returns high immediately (asynchronously), the frame is abandoned, and done=1.

Optional Feature:
UART_TX_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame is 11 bit periods; done returns high at k+11*CLKS_PER_BIT.
- Undefined: no PARITY state or logic; 8N1 framing with 10 bit periods.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, STOP, PARITY)
  - UART_IDLE_LVL=1, UART_START_LVL=0, UART_STOP_LVL=1
  - DATA_BITS=8
  - default CLKS_PER_BIT constant
- One natural sub-module, uart_baud_cnt: counter with clear input and bit_tick output at count CLKS_PER_BIT-1. It is reused by the future RX block.

Test Plan:
- Reset: hold rst_n=0 with CLKS_PER_BIT=4 -> serial=1, done=1, active=0; release and idle 20 cycles -> outputs unchanged.
- Single byte: send 0x53 ('S') at edge k -> done falls at k; line low over k..k+3; then bits 1,1,0,0,1,0,1,0 at 4 cycles each; high for k+36..k+39; done=1 at k+40.
- Busy ignore: start 0xA5, pulse valid with 0xFF at k+10 -> only the 0xA5 frame appears; done rises at k+40; no second frame.
- Controller handshake: drive "SI-SIM1-P-#" plus 0x0D through controller-style SEND/WAIT -> 12 frames, decoded bytes match in order, no repeats.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 -> line high and done=1 within the same cycle; the next 0x0D request transmits a correct frame.
- Parity build (UART_TX_PARITY_EN): send 0x07 -> parity bit 1 after bit 7; done at k+44; send 0x03 -> parity bit 0.
